// File: rtl/fetch_stage_if.sv
// ============================================================================
//  fetch_stage_if
//  Instruction-memory, decode and redirect signals of the fetch stage.
//  Optional port: perf_stall_cycles when FETCH_PERF_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cycles;
`endif

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output ifid_valid,
    output ifid_instr,
`ifdef FETCH_PERF_EN
    output perf_stall_cycles,
`endif
    output ifid_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_instr,
`ifdef FETCH_PERF_EN
    input  perf_stall_cycles,
`endif
    input  ifid_pc
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  fetch_stage
//  Program counter, single-outstanding imem fetch and IF/ID register.
//  Optional feature: FETCH_PERF_EN adds a saturating stall-cycle counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    START = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next, pc_inc;
  logic [15:0] hold_instr, hold_instr_next;
  logic [15:0] hold_pc, hold_pc_next;
  logic        ifid_valid, ifid_valid_next;
  logic [15:0] ifid_instr, ifid_instr_next;
  logic [15:0] ifid_pc, ifid_pc_next;
  logic        accept;
  logic        req;
  logic [15:0] addr;

  assign accept = !ifid_valid || !bus.stall;
  assign pc_inc = pc + 16'd1;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    hold_instr_next = hold_instr;
    hold_pc_next    = hold_pc;
    ifid_valid_next = ifid_valid;
    ifid_instr_next = ifid_instr;
    ifid_pc_next    = ifid_pc;
    req             = 1'b0;
    addr            = pc;

    if (bus.redirect_valid) begin
      pc_next         = bus.redirect_pc;
      ifid_valid_next = 1'b0;
      ifid_instr_next = NOP_INSTR;
      hold_instr_next = 16'h0000;
      hold_pc_next    = 16'h0000;
      // A response still in flight must be swallowed before refetching
      if ((state == BUSY || state == DROP) && !bus.imem_valid)
        state_next = DROP;
      else
        state_next = START;
    end else begin
      // Decode took the word (or slot was empty); overridden when a new word lands
      if (accept) begin
        ifid_valid_next = 1'b0;
        ifid_instr_next = NOP_INSTR;
      end
      case (state)
        START: begin
          req        = 1'b1;
          state_next = BUSY;
        end
        BUSY: begin
          if (bus.imem_valid) begin
            pc_next = pc_inc;
            if (accept) begin
              ifid_valid_next = 1'b1;
              ifid_instr_next = bus.imem_rdata;
              ifid_pc_next    = pc;
              req             = 1'b1;
              addr            = pc_inc;
            end else begin
              hold_instr_next = bus.imem_rdata;
              hold_pc_next    = pc;
              state_next      = HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            ifid_valid_next = 1'b1;
            ifid_instr_next = hold_instr;
            ifid_pc_next    = hold_pc;
            req             = 1'b1;
            state_next      = BUSY;
          end
        end
        DROP: begin
          if (bus.imem_valid)
            state_next = START;
        end
        default: state_next = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= START;
      pc         <= RESET_PC;
      hold_instr <= 16'h0000;
      hold_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 16'h0000;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      hold_instr <= hold_instr_next;
      hold_pc    <= hold_pc_next;
      ifid_valid <= ifid_valid_next;
      ifid_instr <= ifid_instr_next;
      ifid_pc    <= ifid_pc_next;
    end
  end

  assign bus.imem_req   = req && !reset;
  assign bus.imem_addr  = addr;
  assign bus.ifid_valid = ifid_valid;
  assign bus.ifid_instr = ifid_instr;
  assign bus.ifid_pc    = ifid_pc;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      perf_cnt <= 16'h0000;
    else if (((ifid_valid && bus.stall) || state == HOLD) && perf_cnt != 16'hFFFF)
      perf_cnt <= perf_cnt + 16'd1;
  end

  assign bus.perf_stall_cycles = perf_cnt;
`endif

endmodule

`default_nettype wire
